// File: rtl/merge_pkg.sv
// Shared types and constants for the two-input stream merger.
package merge_pkg;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } arb_state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux2x1_nbit.sv
// Bitwise 2:1 data mux; each sel bit picks d1_i (1) or d0_i (0) for its lane.
module mux2x1_nbit #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] d0_i,
    input  logic [N-1:0] d1_i,
    input  logic [N-1:0] sel_i,
    output logic [N-1:0] y_o
);

    assign y_o = (sel_i & d1_i) | (~sel_i & d0_i);

endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; priority flips only when a grant is consumed.
module rr_arb2
    import merge_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic grant_a,
    output logic grant_b
);

    arb_state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRI_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        state_d = state_q;
        unique case (state_q)
            PRI_A: begin
                grant_a = req_a;
                grant_b = req_b && !req_a;
            end
            PRI_B: begin
                grant_b = req_b;
                grant_a = req_a && !req_b;
            end
            default: ;
        endcase
        // A grant that is not consumed (advance low) keeps the current priority.
        if (advance && grant_a) begin
            state_d = PRI_B;
        end else if (advance && grant_b) begin
            state_d = PRI_A;
        end
    end

endmodule

// File: rtl/stream_merge2x1.sv
// Round-robin merge of two valid/ready streams into one registered output stream.
// Optional MERGE_SRC_TAG_EN adds out_src (0 = A, 1 = B), registered with out_data.
module stream_merge2x1
    import merge_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a_data,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [N-1:0] b_data,
    input  logic         b_valid,
    output logic         b_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
`ifdef MERGE_SRC_TAG_EN
    ,
    output logic         out_src
`endif
);

    logic [N-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic [N-1:0] mux_y;
    logic         load;
    logic         grant_a, grant_b;
    logic         xfer_a, xfer_b, xfer;

    // Single-entry register with pass-through ready.
    assign load = !valid_q || out_ready;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (a_valid),
        .req_b   (b_valid),
        .advance (load),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    mux2x1_nbit #(
        .N (N)
    ) u_mux (
        .d0_i  (b_data),
        .d1_i  (a_data),
        .sel_i ({N{grant_a}}),
        .y_o   (mux_y)
    );

    // Readies are held low for the whole time reset is asserted.
    assign a_ready = rst_n && load && grant_a;
    assign b_ready = rst_n && load && grant_b;
    assign xfer_a  = a_valid && a_ready;
    assign xfer_b  = b_valid && b_ready;
    assign xfer    = xfer_a || xfer_b;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = xfer;
        end
        if (xfer) begin
            data_d = mux_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

`ifdef MERGE_SRC_TAG_EN
    logic src_q, src_d;

    always_comb begin
        src_d = src_q;
        if (xfer) begin
            src_d = xfer_b ? SRC_B : SRC_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= SRC_A;
        end else begin
            src_q <= src_d;
        end
    end

    assign out_src = src_q;
`else
    // No source tag: nothing further to register.
`endif

endmodule

// File: tb/tb_stream_merge2x1.sv
// Directed self-checking bench for stream_merge2x1 (N = 4).
module tb_stream_merge2x1;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] a_data;
    logic         a_valid;
    logic         a_ready;
    logic [N-1:0] b_data;
    logic         b_valid;
    logic         b_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
`ifdef MERGE_SRC_TAG_EN
    logic         out_src;
`endif

    int n_cmp;
    int n_err;

    stream_merge2x1 #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MERGE_SRC_TAG_EN
        ,
        .out_src   (out_src)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_data    = '0;
        b_data    = '0;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        a_data    = 4'h7;
        b_data    = 4'h9;
        out_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_data !== 4'h0) begin
            n_err++; $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        n_cmp++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready: got a=%b b=%b want a=0 b=0", a_ready, b_ready);
        end
`ifdef MERGE_SRC_TAG_EN
        n_cmp++;
        if (out_src !== 1'b0) begin
            n_err++; $display("FAIL reset_out_src: got %b want 0", out_src);
        end
`endif
        @(negedge clk);
        rst_n   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_single_a();
        apply_reset();
        a_valid = 1'b1;
        a_data  = 4'h3;
        #1;
        n_cmp++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_err++; $display("FAIL single_a_first_ready: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 4'h3) begin
                n_err++; $display("FAIL single_a_out[%0d]: got v=%b d=%h want v=1 d=3", i, out_valid, out_data);
            end
            n_cmp++;
            if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
                n_err++; $display("FAIL single_a_ready[%0d]: got a=%b b=%b want a=1 b=0", i, a_ready, b_ready);
            end
        end
        a_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL single_a_drain: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_alternate();
        logic [N-1:0] exp_d [4];
        logic         exp_a [4];
        exp_d = '{4'hA, 4'h5, 4'hA, 4'h5};
        exp_a = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        a_valid = 1'b1; a_data = 4'hA;
        b_valid = 1'b1; b_data = 4'h5;
        #1;
        n_cmp++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_err++; $display("FAIL alt_first_grant: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
                n_err++; $display("FAIL alt_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_d[i]);
            end
            n_cmp++;
            if (a_ready !== exp_a[i] || b_ready !== !exp_a[i]) begin
                n_err++; $display("FAIL alt_grant[%0d]: got a=%b b=%b want a=%b b=%b", i, a_ready, b_ready, exp_a[i], !exp_a[i]);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_stall();
        apply_reset();
        a_valid = 1'b1; a_data = 4'hA;
        b_valid = 1'b1; b_data = 4'h5;
        step();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 4'hA) begin
                n_err++; $display("FAIL stall_hold[%0d]: got v=%b d=%h want v=1 d=a", i, out_valid, out_data);
            end
            n_cmp++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_ready[%0d]: got a=%b b=%b want a=0 b=0", i, a_ready, b_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_release_grant: got a=%b b=%b want a=0 b=1", a_ready, b_ready);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'h5) begin
            n_err++; $display("FAIL stall_release_out: got v=%b d=%h want v=1 d=5", out_valid, out_data);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        a_valid = 1'b1; a_data = 4'h1;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1; b_data = 4'hC;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || b_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_pre: got v=%b b_ready=%b want v=1 b_ready=1", out_valid, b_ready);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'hC) begin
            n_err++; $display("FAIL b2b_out: got v=%b d=%h want v=1 d=c", out_valid, out_data);
        end
        b_valid = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        apply_reset();
        a_valid = 1'b1; a_data = 4'hA;
        b_valid = 1'b1; b_data = 4'h5;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 4'h0) begin
            n_err++; $display("FAIL midrst_out: got v=%b d=%h want v=0 d=0", out_valid, out_data);
        end
        n_cmp++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_err++; $display("FAIL midrst_ready: got a=%b b=%b want a=0 b=0", a_ready, b_ready);
        end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_err++; $display("FAIL midrst_grant: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'hA) begin
            n_err++; $display("FAIL midrst_out_after: got v=%b d=%h want v=1 d=a", out_valid, out_data);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

`ifdef MERGE_SRC_TAG_EN
    task automatic test_src_tag();
        logic exp_s [4];
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        a_valid = 1'b1; a_data = 4'h2;
        b_valid = 1'b1; b_data = 4'hE;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (out_src !== exp_s[i] || out_data !== (exp_s[i] ? 4'hE : 4'h2)) begin
                n_err++; $display("FAIL tag[%0d]: got src=%b d=%h want src=%b", i, out_src, out_data, exp_s[i]);
            end
        end
        out_ready = 1'b0;
        step();
        step();
        n_cmp++;
        if (out_src !== 1'b1 || out_data !== 4'hE) begin
            n_err++; $display("FAIL tag_stall: got src=%b d=%h want src=1 d=e", out_src, out_data);
        end
        out_ready = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_a();
        test_alternate();
        test_stall();
        test_back_to_back();
        test_mid_reset();
`ifdef MERGE_SRC_TAG_EN
        test_src_tag();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
